// File: rtl/cpu_types_pkg.sv
// Shared types for the two-core coherent memory bus: RAM handshake states,
// bus controller FSM states and the request classes used by arbitration.
package cpu_types_pkg;

  localparam int BUS_CPUS = 2;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    MEM,
    SNOOP1,
    SNOOP2,
    SUPPLY0,
    SUPPLY1,
    FILL0,
    FILL1
  } bus_state_t;

  // Ordered from highest to lowest arbitration priority.
  typedef enum logic [1:0] {
    CLS_EVICT,
    CLS_COH,
    CLS_IFETCH
  } req_class_t;

  // Round-robin pick between two requesters: the favoured core wins a tie.
  function automatic logic rr_pick(input logic [1:0] req, input logic rr);
    return req[rr] ? rr : ~rr;
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_arbiter.sv
// bus_arbiter: combinational grant selection for the coherent bus.
// Strict priority across classes (eviction, coherent miss, ifetch), with a
// round-robin tie break between the two cores inside a class.
module bus_arbiter
  import cpu_types_pkg::*;
(
  input  logic [1:0] iren_i,
  input  logic [1:0] dren_i,
  input  logic [1:0] dwen_i,
  input  logic [1:0] cctrans_i,
  input  logic       rr_i,
  output logic       vld_o,
  output logic       gnt_o,
  output req_class_t cls_o
);

  logic [1:0] evict;
  logic [1:0] coh;

  assign evict = dwen_i & ~cctrans_i;
  assign coh   = dren_i & cctrans_i;

  // Pick the highest non-empty class, then the round-robin winner inside it.
  always_comb begin
    vld_o = 1'b1;
    gnt_o = 1'b0;
    cls_o = CLS_IFETCH;
    if (|evict) begin
      cls_o = CLS_EVICT;
      gnt_o = rr_pick(evict, rr_i);
    end else if (|coh) begin
      cls_o = CLS_COH;
      gnt_o = rr_pick(coh, rr_i);
    end else if (|iren_i) begin
      cls_o = CLS_IFETCH;
      gnt_o = rr_pick(iren_i, rr_i);
    end else begin
      vld_o = 1'b0;
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: two-core MSI snooping bus controller in front of a
// single shared RAM port. Blocks are two words, moved one word per RAM access.
// Optional feature macro: COHERENCE_C2C_EN -- a Modified block supplied by the
// snoopee is also forwarded straight to the requester and the RAM refill is
// skipped.
module coherence_bus_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CPUS = BUS_CPUS
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [CPUS-1:0] iREN,
  input  logic [31:0]     iaddr       [CPUS],
  output logic [CPUS-1:0] iwait,
  output logic [31:0]     iload       [CPUS],
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  logic [31:0]     daddr       [CPUS],
  input  logic [31:0]     dstore      [CPUS],
  output logic [CPUS-1:0] dwait,
  output logic [31:0]     dload       [CPUS],
  input  logic [CPUS-1:0] cctrans,
  input  logic [CPUS-1:0] ccwrite,
  output logic [CPUS-1:0] ccwait,
  output logic [CPUS-1:0] ccinv,
  output logic [31:0]     ccsnoopaddr [CPUS],
  output logic            ramREN,
  output logic            ramWEN,
  output logic [31:0]     ramaddr,
  output logic [31:0]     ramstore,
  input  logic [31:0]     ramload,
  input  ramstate_t       ramstate
);

  bus_state_t state_q, state_d;
  req_class_t cls_q, cls_d;
  logic       rr_q, rr_d;
  logic       g_q, g_d;
  logic       inv_q, inv_d;

  logic       arb_vld;
  logic       arb_gnt;
  req_class_t arb_cls;
  logic       s;
  logic       acc;

  assign s   = ~g_q;
  assign acc = (ramstate == ACCESS);

  bus_arbiter u_arb (
    .iren_i    (iREN),
    .dren_i    (dREN),
    .dwen_i    (dWEN),
    .cctrans_i (cctrans),
    .rr_i      (rr_q),
    .vld_o     (arb_vld),
    .gnt_o     (arb_gnt),
    .cls_o     (arb_cls)
  );

  // Controller state, grant, request class, latched invalidate and rr pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cls_q   <= CLS_IFETCH;
      rr_q    <= 1'b0;
      g_q     <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      inv_q   <= inv_d;
    end
  end

  // Next-state logic and all bus/RAM outputs decoded from the registered state.
  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    rr_d     = rr_q;
    g_d      = g_q;
    inv_d    = inv_q;
    iwait    = '1;
    dwait    = '1;
    ccwait   = '0;
    ccinv    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    for (int i = 0; i < CPUS; i++) begin
      iload[i]       = '0;
      dload[i]       = '0;
      ccsnoopaddr[i] = '0;
    end

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          g_d   = arb_gnt;
          cls_d = arb_cls;
          if (arb_cls == CLS_COH) begin
            state_d = SNOOP1;
            inv_d   = ccwrite[arb_gnt];
          end else begin
            state_d = MEM;
          end
        end
      end
      MEM: begin
        if (cls_q == CLS_EVICT) begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[g_q];
          ramstore = dstore[g_q];
          if (acc) dwait[g_q] = 1'b0;
        end else begin
          ramREN       = 1'b1;
          ramaddr      = iaddr[g_q];
          iload[g_q]   = ramload;
          if (acc) iwait[g_q] = 1'b0;
        end
        if (acc) begin
          state_d = IDLE;
          rr_d    = ~rr_q;
        end
      end
      SNOOP1: state_d = SNOOP2;
      SNOOP2: begin
        // A snoopee holding the block Modified answers with a writeback.
        if (dWEN[s] && cctrans[s]) state_d = SUPPLY0;
        else                       state_d = FILL0;
      end
      SUPPLY0, SUPPLY1: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[s];
        ramstore = dstore[s];
        if (acc) begin
          dwait[s] = 1'b0;
`ifdef COHERENCE_C2C_EN
          dload[g_q] = dstore[s];
          dwait[g_q] = 1'b0;
`endif
          if (state_q == SUPPLY0) begin
            state_d = SUPPLY1;
          end else begin
`ifdef COHERENCE_C2C_EN
            state_d = IDLE;
            rr_d    = ~rr_q;
`else
            state_d = FILL0;
`endif
          end
        end
      end
      FILL0, FILL1: begin
        ramREN     = 1'b1;
        ramaddr    = daddr[g_q];
        dload[g_q] = ramload;
        if (acc) begin
          dwait[g_q] = 1'b0;
          if (state_q == FILL0) begin
            state_d = FILL1;
          end else begin
            state_d = IDLE;
            rr_d    = ~rr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The snoopee stays stalled from the snoop through its own writeback.
    if (state_q inside {SNOOP1, SNOOP2, SUPPLY0, SUPPLY1}) begin
      ccwait[s]      = 1'b1;
      ccinv[s]       = inv_q;
      ccsnoopaddr[s] = daddr[g_q];
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed + randomized bench for coherence_bus_ctrl. The bench plays both
// caches and the RAM; a word-level reference memory predicts every load.
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  iREN, dREN, dWEN, cctrans, ccwrite;
  logic [1:0]  iwait, dwait, ccwait, ccinv;
  logic [31:0] iaddr [2];
  logic [31:0] daddr [2];
  logic [31:0] dstore [2];
  logic [31:0] iload [2];
  logic [31:0] dload [2];
  logic [31:0] ccsnoopaddr [2];
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  logic [31:0] ram  [256];
  logic [31:0] refm [256];
  int vectors = 0;
  int miscompares = 0;
  int t0, t1, te, ti;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_reqs();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    for (int i = 0; i < 2; i++) begin
      iaddr[i] = '0; daddr[i] = '0; dstore[i] = '0;
    end
  endtask

  // Let combinational outputs settle and present the RAM read data.
  task automatic settle();
    #1;
    ramload = ram[ramaddr[9:2]];
    #1;
  endtask

  // Commit a RAM write accepted this cycle, then move past the next edge.
  task automatic step();
    if (ramWEN && ramstate == ACCESS) ram[ramaddr[9:2]] = ramstore;
    @(posedge CLK);
    #1;
  endtask

  // Both cores fetch together; returns the cycle each sees iwait low.
  task automatic dual_ifetch(output int c0, output int c1);
    c0 = 0; c1 = 0;
    iREN = 2'b11; iaddr[0] = 32'h10; iaddr[1] = 32'h20; ramstate = ACCESS;
    for (int k = 1; k <= 10 && iREN != 2'b00; k++) begin
      settle();
      if (iREN[0] && !iwait[0]) begin
        c0 = k; chk("dual_iload0", iload[0], refm[4]); iREN[0] = 1'b0;
      end
      if (iREN[1] && !iwait[1]) begin
        c1 = k; chk("dual_iload1", iload[1], refm[8]); iREN[1] = 1'b0;
      end
      step();
    end
    idle_reqs();
  endtask

  // One transaction from core c. kind 0 ifetch, 1 eviction, 2 coherent miss
  // of the block at a (snoopee supplies d0/d1 when sup). busy = BUSY cycles
  // the RAM inserts before accepting the first access.
  task automatic xact(input int kind, input logic c, input logic [31:0] a,
                      input logic sup, input logic wr, input logic [31:0] d0,
                      input logic [31:0] d1, input int busy);
    logic s;
    logic [31:0] ea;
    int n, w, sd, bleft, lat, exp_lat;
    bit done;
    s = ~c; n = 0; w = 0; sd = 0; bleft = busy; lat = 0; done = 0;
    idle_reqs();
    case (kind)
      0: begin iREN[c] = 1'b1; iaddr[c] = a; exp_lat = 2 + busy; end
      1: begin dWEN[c] = 1'b1; daddr[c] = a; dstore[c] = d0; exp_lat = 2 + busy; end
      default: begin
        dREN[c] = 1'b1; cctrans[c] = 1'b1; ccwrite[c] = wr; daddr[c] = a;
`ifdef COHERENCE_C2C_EN
        exp_lat = 4 + busy;
`else
        exp_lat = sup ? 6 + busy : 4 + busy;
`endif
      end
    endcase
    while (!done && n < 40) begin
      n++;
      ramstate = (bleft > 0) ? BUSY : ACCESS;
      #1;
      if (kind == 2 && sup && ccwait[s] && sd < 2) begin
        dWEN[s] = 1'b1; cctrans[s] = 1'b1;
        daddr[s] = a + 32'(4 * sd); dstore[s] = (sd == 0) ? d0 : d1;
      end else if (kind == 2) begin
        dWEN[s] = 1'b0; cctrans[s] = 1'b0;
      end
      settle();
      if (n == 1) chk("idle_no_strobe", {30'b0, ramREN, ramWEN}, 0);
      if (kind == 2 && (n == 2 || n == 3)) begin
        chk("snoop_ccwait", {30'b0, ccwait}, s ? 2 : 1);
        chk("snoop_ccinv", {31'b0, ccinv[s]}, {31'b0, wr});
        chk("snoop_addr", ccsnoopaddr[s], a);
      end
      if (kind == 2 && ramREN) chk("fill_ccwait_low", {30'b0, ccwait}, 0);
      if ((ramREN || ramWEN) && ramstate == BUSY) begin
        bleft--;
        chk("busy_waits_high", {28'b0, iwait, dwait}, 32'hF);
        chk("busy_addr_held", ramaddr, a);
      end else begin
        case (kind)
          0: if (!iwait[c]) begin
            chk("ifetch_data", iload[c], refm[a[9:2]]);
            lat = n; done = 1; iREN[c] = 1'b0;
          end
          1: if (!dwait[c]) begin
            chk("evict_addr", ramaddr, a);
            chk("evict_data", ramstore, d0);
            refm[a[9:2]] = d0;
            lat = n; done = 1; dWEN[c] = 1'b0;
          end
          default: begin
            if (sup && !dwait[s]) begin
              chk("supply_wen", {31'b0, ramWEN}, 1);
              chk("supply_addr", ramaddr, a + 32'(4 * sd));
              chk("supply_data", ramstore, (sd == 0) ? d0 : d1);
              sd++;
            end
            if (!dwait[c]) begin
              ea = a + 32'(4 * w);
              chk("miss_data", dload[c], sup ? ((w == 0) ? d0 : d1) : refm[ea[9:2]]);
              if (w == 0) lat = n;
              w++;
              daddr[c] = a + 32'(4 * w);
              if (w == 2) begin done = 1; dREN[c] = 1'b0; cctrans[c] = 1'b0; end
            end
          end
        endcase
      end
      step();
    end
    if (!done) chk("txn_timeout", 0, 1);
    chk("first_word_latency", lat, exp_lat);
    if (kind == 2 && sup) begin
      chk("supply_words", sd, 2);
      refm[a[9:2]] = d0;
      refm[a[9:2] + 8'd1] = d1;
    end
    idle_reqs();
  endtask

  initial begin
    RST = 1'b1;
    idle_reqs();
    ramstate = FREE;
    ramload = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom;
      refm[i] = ram[i];
    end
    #2;
    // Reset state
    chk("rst_iwait", {30'b0, iwait}, 3);
    chk("rst_dwait", {30'b0, dwait}, 3);
    chk("rst_ccwait", {30'b0, ccwait}, 0);
    chk("rst_ccinv", {30'b0, ccinv}, 0);
    chk("rst_strobes", {30'b0, ramREN, ramWEN}, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_dload0", dload[0], 0);
    chk("rst_iload1", iload[1], 0);
    chk("rst_snoopaddr1", ccsnoopaddr[1], 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    ramstate = ACCESS;

    // Simultaneous fetches from rr=0, twice (rr returns to 0 each time)
    dual_ifetch(t0, t1);
    chk("dual_core0_cycle", t0, 2);
    chk("dual_core1_cycle", t1, 4);
    dual_ifetch(t0, t1);
    chk("dual2_core0_cycle", t0, 2);
    chk("dual2_core1_cycle", t1, 4);

    // Eviction beats ifetch regardless of rr
    dWEN[1] = 1'b1; daddr[1] = 32'h40; dstore[1] = 32'h1234_5678;
    iREN[0] = 1'b1; iaddr[0] = 32'h40;
    te = 0; ti = 0;
    for (int k = 1; k <= 6; k++) begin
      settle();
      if (k == 2) begin
        chk("prio_ramwen", {31'b0, ramWEN}, 1);
        chk("prio_ramaddr", ramaddr, 32'h40);
        chk("prio_ramstore", ramstore, 32'h1234_5678);
        chk("prio_iwait0_high", {31'b0, iwait[0]}, 1);
      end
      if (dWEN[1] && !dwait[1]) begin te = k; dWEN[1] = 1'b0; refm[16] = 32'h1234_5678; end
      if (iREN[0] && !iwait[0]) begin ti = k; chk("prio_iload", iload[0], refm[16]); iREN[0] = 1'b0; end
      step();
    end
    chk("prio_evict_cycle", te, 2);
    chk("prio_ifetch_cycle", ti, 4);
    idle_reqs();

    // One single fetch leaves rr=1, so core1 now wins the tie
    xact(0, 1'b0, 32'h30, 1'b0, 1'b0, 0, 0, 0);
    dual_ifetch(t0, t1);
    chk("rr1_core1_cycle", t1, 2);
    chk("rr1_core0_cycle", t0, 4);

    // Coherent miss, no supplier, then with a Modified supplier
    xact(2, 1'b0, 32'h100, 1'b0, 1'b1, 0, 0, 0);
    xact(2, 1'b0, 32'h100, 1'b1, 1'b1, 32'hAAAA, 32'hBBBB, 0);
    chk("supply_ram_word0", ram[64], 32'hAAAA);
    chk("supply_ram_word1", ram[65], 32'hBBBB);

    // RAM BUSY for 3 cycles during MEM
    xact(0, 1'b1, 32'h80, 1'b0, 1'b0, 0, 0, 3);

    // Randomized transactions against the reference memory
    for (int t = 0; t < 40; t++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 2);
      if (k == 2) a = {22'b0, 7'($urandom_range(0, 127)), 3'b0};
      else        a = {22'b0, 8'($urandom_range(0, 255)), 2'b0};
      xact(k, 1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 2));
    end

    // Reset while parked in FILL0 behind a BUSY RAM
    idle_reqs();
    dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h200;
    ramstate = BUSY;
    repeat (3) step();
    settle();
    chk("fill0_ramren", {31'b0, ramREN}, 1);
    chk("fill0_ramaddr", ramaddr, 32'h200);
    RST = 1'b1;
    #1;
    chk("midrst_dwait", {30'b0, dwait}, 3);
    chk("midrst_ramren", {31'b0, ramREN}, 0);
    step();
    settle();
    chk("midrst_dwait_next", {30'b0, dwait}, 3);
    chk("midrst_ramren_next", {31'b0, ramREN}, 0);
    chk("midrst_ccwait_next", {30'b0, ccwait}, 0);
    RST = 1'b0;
    idle_reqs();
    ramstate = ACCESS;
    step();
    xact(0, 1'b0, 32'h14, 1'b0, 1'b0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coherence_bus_ctrl.md
# coherence_bus_ctrl

Two-core snooping memory bus controller between the per-core icache/dcache pairs and the single shared RAM port. It arbitrates instruction fetches, dirty-block writebacks and coherent dcache fills. It sequences the MSI snoop handshake (ccwait/ccsnoopaddr/ccinv/cctrans) on the non-requesting dcache. It moves each two-word block one word per RAM transaction.

## Interface
- CPUS, 2: number of cores; only 2 supported.
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  [CPUS]  icache read request per core.
- iaddr  in  [CPUS]x32  icache word address.
- iwait  out  [CPUS]  low for exactly the cycle iload is valid.
- iload  out  [CPUS]x32  fetched instruction.
- dREN, dWEN  in  [CPUS]  dcache read / write request.
- daddr, dstore  in  [CPUS]x32  dcache word address / write data.
- dwait  out  [CPUS]  low for the completing cycle of a dcache word.
- dload  out  [CPUS]x32  dcache read data.
- cctrans  in  [CPUS]  on a requester: coherent miss; on a snoopee: supplying a Modified block.
- ccwrite  in  [CPUS]  requester intends to write (BusRdX).
- ccwait  out  [CPUS]  snoopee must service the snoop, stall its datapath.
- ccinv  out  [CPUS]  snoopee must invalidate the snooped block.
- ccsnoopaddr  out  [CPUS]x32  address being snooped.
- ramREN, ramWEN  out  1  RAM read / write strobe.
- ramaddr, ramstore  out  32  RAM address / write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE, BUSY, ACCESS, ERROR.

## Operation
- States: IDLE, MEM, SNOOP1, SNOOP2, SUPPLY0, SUPPLY1, FILL0, FILL1. A 1-bit round-robin pointer `rr` selects which core wins first.
- IDLE priority classes, highest first: dWEN without cctrans (eviction), then dREN with cctrans (coherent miss), then iREN. Within a class, core `rr` wins ties. The grant is registered as `g`; the snoopee is `s = ~g`.
- Eviction or iREN goes to MEM. This is a single-word RAM access sourced from core g.
- Coherent dREN goes to SNOOP1. Drive ccwait[s]=1, ccsnoopaddr[s]=daddr[g] and ccinv[s]=ccwrite[g]. These are held through SNOOP2 and SUPPLY0/1.
- SNOOP2 exit:
  - dWEN[s]&&cctrans[s]: go to SUPPLY0.
  - Otherwise: go to FILL0 and drop ccwait[s] and ccinv[s].
- SUPPLY0/1: drive ramWEN with daddr[s]/dstore[s]. On ACCESS, pull dwait[s] low and advance. After SUPPLY1, go to FILL0.
- FILL0/1: drive ramREN with daddr[g]. On ACCESS, pull dwait[g] low with dload[g]=ramload. After FILL1, go to IDLE.
- MEM exit: on ACCESS, pull the matching wait low and go to IDLE.
- rr toggles on every return to IDLE.
- ramstate BUSY or ERROR: hold the state and all strobes (retry).
- An iREN and a dREN from the same core are never granted together.

## Timing
- Reset values:
  - state=IDLE, rr=0.
  - iwait=dwait='1, ccwait=ccinv='0.
  - ccsnoopaddr, iload, dload, ramaddr, ramstore = 0.
  - ramREN=ramWEN=0.
- RST mid-transaction aborts to IDLE with no partial writes tracked.
- Outputs are combinational from registered state/grant. RAM strobes rise in the first cycle of MEM, SUPPLY or FILL, never in IDLE.
- Minimum latency with RAM ACCESS on its first cycle:
  - MEM: 2 cycles request-to-wait-low.
  - Coherent miss without supplier: 4 cycles to first word.
- A request deasserted before grant is dropped. A request held in IDLE is granted the next cycle.
- Both cores issuing coherent misses to the same block: serialized. The second core snoops the first core's fresh copy.
- Arbitration is strict priority across classes and round-robin only within a class.

## Configuration
- COHERENCE_C2C_EN defined:
  - In SUPPLY0/1, the requester also gets dload[g]=dstore[s] with dwait[g] low in the same ACCESS cycle.
  - After SUPPLY1, the FSM returns to IDLE and skips FILL.
- Undefined: the supplier writes back to RAM and the requester re-reads via FILL0/1. This is correct but costs 2 extra RAM accesses.

## Structure
- cpu_types_pkg gains:
  - bus_state_t (FSM enum).
  - ramstate_t (if absent).
  - constant BUS_CPUS=2.
- One sub-module `bus_arbiter`: combinational class priority plus round-robin pick, producing grant index and class.

## Test plan
- Reset with RST=1 mid-FILL0 → state IDLE, dwait=2'b11, ramREN=0 the next cycle.
- iREN[0] and iREN[1] together, rr=0, RAM ACCESS immediate → core0 iwait low in cycle 2, core1 in cycle 4; rr ends at 0.
- dWEN[1] eviction and iREN[0] same cycle → eviction served first; ramWEN=1, ramaddr=daddr[1].
- Core0 coherent dREN 0x100 with ccwrite=1; core1 no supplier → ccwait[1]=1, ccinv[1]=1, ccsnoopaddr[1]=0x100 for 2 cycles; then two RAM reads 0x100/0x104.
- Same as above, but core1 supplies dirty words 0xAAAA/0xBBBB:
  - RAM writes 0x100/0x104.
  - With COHERENCE_C2C_EN, dload[0]=0xAAAA/0xBBBB and no FILL.
  - Without it, FILL reads back 0xAAAA/0xBBBB.
- ramstate=BUSY for 3 cycles during MEM → strobes held stable and wait stays high until ACCESS.
